// File: rtl/gpu_pkg.sv
// Shared GPU definitions: opcode set, instruction field layout, program-size
// defaults and the fetch front-end state encoding.
package gpu_pkg;

   localparam int INSTR_WIDTH_DEFAULT = 32;
   localparam int INSTR_COUNT_DEFAULT = 512;

   typedef enum logic [3:0] {
      OP_NOP,
      OP_LOAD,
      OP_STORE,
      OP_ADD,
      OP_SUB,
      OP_MUL,
      OP_CMP,
      OP_END,
      OP_JUMP
   } opcode_t;

   // Instruction word layout: [opcode | reg A | immediate | reg B | reg C]
   localparam int OPCODE_MSB = 31;
   localparam int OPCODE_LSB = 28;
   localparam int REG_A_MSB  = 27;
   localparam int REG_A_LSB  = 24;
   localparam int IMM_MSB    = 23;
   localparam int IMM_LSB    = 8;
   localparam int REG_B_MSB  = 7;
   localparam int REG_B_LSB  = 4;
   localparam int REG_C_MSB  = 3;
   localparam int REG_C_LSB  = 0;

   typedef enum logic [1:0] {
      FETCH_IDLE,
      FETCH_RUN,
      FETCH_END_HOLD
   } fetch_state_t;

   function automatic opcode_t opcode_of(input logic [INSTR_WIDTH_DEFAULT-1:0] instr);
      return opcode_t'(instr[OPCODE_MSB:OPCODE_LSB]);
   endfunction

endpackage

// File: rtl/instr_fifo.sv
// First-word-fall-through FIFO: the head entry is visible on rd_data whenever
// count is non-zero. Synchronous flush clears it regardless of rd_en/wr_en.
module instr_fifo #(
   parameter int DATA_W = 41,
   parameter int DEPTH  = 4,
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   input  logic              wr_en,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_en,
   output logic [DATA_W-1:0] rd_data,
   output logic [CNT_W-1:0]  count
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PTR_W-1:0] LAST_SLOT = PTR_W'(DEPTH - 1);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr, rd_ptr;
   logic              do_wr, do_rd;

   assign do_wr   = wr_en;
   assign do_rd   = rd_en && (count != '0);
   assign rd_data = mem[rd_ptr];

   // NOTE: state registers use non-blocking assignments so every flop samples
   // pre-edge values, independent of the order the always blocks are evaluated.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_wr) wr_ptr <= (wr_ptr == LAST_SLOT) ? '0 : wr_ptr + 1'b1;
         if (do_rd) rd_ptr <= (rd_ptr == LAST_SLOT) ? '0 : rd_ptr + 1'b1;
         case ({do_wr, do_rd})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // NOTE: the storage array has no reset; count/pointers gate every read, so
   // clearing it would only cost reset fan-out and block RAM inference.
   always_ff @(posedge clk) begin
      if (do_wr && !flush) mem[wr_ptr] <= wr_data;
   end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch front-end: issues BRAM reads under a credit limit, tags them through
// the fixed read latency and buffers returned words for the controller.
module instruction_fetch
   import gpu_pkg::*;
#(
   parameter int INSTRUCTION_WIDTH = INSTR_WIDTH_DEFAULT,
   parameter int INSTRUCTION_COUNT = INSTR_COUNT_DEFAULT,
   parameter int BRAM_LATENCY      = 2,
   parameter int FIFO_DEPTH        = 4,
   localparam int PC_W             = $clog2(INSTRUCTION_COUNT)
) (
   input  logic                         clk_in,
   input  logic                         rst_n_in,
   input  logic                         start_in,
   input  logic                         halt_in,
   input  logic                         redirect_in,
   input  logic [PC_W-1:0]              redirect_pc_in,
   output logic                         bram_en_out,
   output logic [PC_W-1:0]              bram_addr_out,
   input  logic [INSTRUCTION_WIDTH-1:0] bram_data_in,
   output logic [INSTRUCTION_WIDTH-1:0] instr_out,
   output logic [PC_W-1:0]              instr_pc_out,
   output logic                         instr_valid_out,
   input  logic                         instr_ready_in,
   output logic                         busy_out
);

   localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);
   localparam int ENTRY_W = INSTRUCTION_WIDTH + PC_W;
   localparam logic [PC_W-1:0] LAST_PC = PC_W'(INSTRUCTION_COUNT - 1);

   fetch_state_t            state, state_nxt;
   logic [PC_W-1:0]         fetch_pc, fetch_pc_nxt, target_pc;
   logic [BRAM_LATENCY-1:0] tag_valid;
   logic [PC_W-1:0]         tag_pc [BRAM_LATENCY];
   logic [CNT_W-1:0]        fifo_count, inflight_count;
   logic [ENTRY_W-1:0]      head;
   logic                    issue, flush, head_valid, pop;

   always_comb begin
      inflight_count = '0;
      for (int i = 0; i < BRAM_LATENCY; i++) inflight_count += CNT_W'(tag_valid[i]);
   end

   // Credit counts buffered plus in-flight words; a same-cycle pop is not credited.
   assign issue = (state == FETCH_RUN) &&
                  (({1'b0, fifo_count} + {1'b0, inflight_count}) < (CNT_W + 1)'(FIFO_DEPTH));
   assign flush     = halt_in || (redirect_in && state != FETCH_IDLE);
   assign target_pc = ({1'b0, redirect_pc_in} > {1'b0, LAST_PC}) ? LAST_PC : redirect_pc_in;

   // NOTE: every always_comb output gets a default first, so no path leaves it
   // unassigned and no latch is inferred.
   always_comb begin
      state_nxt    = state;
      fetch_pc_nxt = fetch_pc;
      if (halt_in) begin
         state_nxt    = FETCH_IDLE;
         fetch_pc_nxt = '0;
      end else begin
         case (state)
            FETCH_IDLE: if (start_in) begin
               state_nxt    = FETCH_RUN;
               fetch_pc_nxt = '0;
            end
            FETCH_RUN: if (redirect_in) begin
               fetch_pc_nxt = target_pc;
            end else if (issue) begin
               if (fetch_pc == LAST_PC) state_nxt = FETCH_END_HOLD;
               else fetch_pc_nxt = fetch_pc + 1'b1;
            end
            FETCH_END_HOLD: if (redirect_in) begin
               state_nxt    = FETCH_RUN;
               fetch_pc_nxt = target_pc;
            end
            default: state_nxt = FETCH_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state    <= FETCH_IDLE;
         fetch_pc <= '0;
      end else begin
         state    <= state_nxt;
         fetch_pc <= fetch_pc_nxt;
      end
   end

   // Tags mirror the BRAM pipeline; a flush kills every word still in flight.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         tag_valid <= '0;
         for (int i = 0; i < BRAM_LATENCY; i++) tag_pc[i] <= '0;
      end else begin
         tag_valid[0] <= issue && !flush;
         tag_pc[0]    <= fetch_pc;
         for (int i = 1; i < BRAM_LATENCY; i++) begin
            tag_valid[i] <= tag_valid[i-1] && !flush;
            tag_pc[i]    <= tag_pc[i-1];
         end
      end
   end

   instr_fifo #(
      .DATA_W (ENTRY_W),
      .DEPTH  (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk_in),
      .rst_n   (rst_n_in),
      .flush   (flush),
      .wr_en   (tag_valid[BRAM_LATENCY-1]),
      .wr_data ({tag_pc[BRAM_LATENCY-1], bram_data_in}),
      .rd_en   (pop),
      .rd_data (head),
      .count   (fifo_count)
   );

   assign head_valid      = (fifo_count != '0);
   assign pop             = head_valid && instr_ready_in;
   assign instr_valid_out = head_valid;
   assign instr_out       = head_valid ? head[INSTRUCTION_WIDTH-1:0] : '0;
   assign instr_pc_out    = head_valid ? head[ENTRY_W-1 -: PC_W] : '0;
   assign bram_en_out     = issue;
   assign bram_addr_out   = issue ? fetch_pc : '0;
   assign busy_out        = (state != FETCH_IDLE);

   // The credit limit guarantees a returning word always finds a free slot.
   assert property (@(posedge clk_in) disable iff (!rst_n_in)
      !(tag_valid[BRAM_LATENCY-1] && fifo_count == CNT_W'(FIFO_DEPTH)));

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed scenarios plus a random phase, with a
// stream model that predicts which PC the controller must accept next.
module tb_instruction_fetch;

   localparam int IW    = 32;
   localparam int IC    = 512;
   localparam int PW    = 9;
   localparam int DEPTH = 4;

   logic          clk_in = 1'b0;
   logic          rst_n_in = 1'b0;
   logic          start_in = 1'b0;
   logic          halt_in = 1'b0;
   logic          redirect_in = 1'b0;
   logic [PW-1:0] redirect_pc_in = '0;
   logic          instr_ready_in = 1'b0;
   logic          bram_en_out;
   logic [PW-1:0] bram_addr_out;
   logic [IW-1:0] bram_data_in;
   logic [IW-1:0] instr_out;
   logic [PW-1:0] instr_pc_out;
   logic          instr_valid_out;
   logic          busy_out;

   logic [IW-1:0] mem [IC];
   logic [IW-1:0] bram_r1, bram_r2;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk_in = ~clk_in;

   instruction_fetch dut (
      .clk_in          (clk_in),
      .rst_n_in        (rst_n_in),
      .start_in        (start_in),
      .halt_in         (halt_in),
      .redirect_in     (redirect_in),
      .redirect_pc_in  (redirect_pc_in),
      .bram_en_out     (bram_en_out),
      .bram_addr_out   (bram_addr_out),
      .bram_data_in    (bram_data_in),
      .instr_out       (instr_out),
      .instr_pc_out    (instr_pc_out),
      .instr_valid_out (instr_valid_out),
      .instr_ready_in  (instr_ready_in),
      .busy_out        (busy_out)
   );

   // Two-stage registered BRAM; no reset, so stale data survives a DUT reset.
   always @(posedge clk_in) begin
      if (bram_en_out) bram_r1 <= mem[bram_addr_out];
      bram_r2 <= bram_r1;
   end
   assign bram_data_in = bram_r2;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   task automatic wait_valid(output int n, input int limit);
      n = 0;
      while (!instr_valid_out && n < limit) begin
         tick();
         n++;
      end
      if (!instr_valid_out) check("wait_valid_timeout", instr_valid_out, 1);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_bram_en"}, bram_en_out, 0);
      check({tag, "_bram_addr"}, bram_addr_out, 0);
      check({tag, "_instr"}, instr_out, 0);
      check({tag, "_instr_pc"}, instr_pc_out, 0);
      check({tag, "_valid"}, instr_valid_out, 0);
      check({tag, "_busy"}, busy_out, 0);
   endtask

   // Stream model: accepted PCs run contiguously from the last start (PC 0) or
   // redirect target up to IC-1; halt or reset ends the stream.
   bit            active = 0;
   bit            stall_hold = 0;
   int            exp_pc = 0;
   int            last_acc = -1;
   logic [PW-1:0] held_pc;
   logic [IW-1:0] held_instr;

   initial begin
      forever begin
         @(negedge clk_in);
         if (!rst_n_in) begin
            active     = 0;
            stall_hold = 0;
         end else begin
            if (!active) begin
               check("idle_valid", instr_valid_out, 0);
            end else if (instr_valid_out) begin
               check("pc", instr_pc_out, 64'(exp_pc));
               check("instr", instr_out, mem[instr_pc_out]);
               if (stall_hold) begin
                  check("hold_pc", instr_pc_out, held_pc);
                  check("hold_instr", instr_out, held_instr);
               end
               if (instr_ready_in) begin
                  last_acc   = int'(instr_pc_out);
                  exp_pc     = exp_pc + 1;
                  stall_hold = 0;
               end else begin
                  stall_hold = 1;
                  held_pc    = instr_pc_out;
                  held_instr = instr_out;
               end
            end else if (stall_hold) begin
               check("hold_valid", instr_valid_out, 1);
            end
            if (halt_in) begin
               active     = 0;
               stall_hold = 0;
            end else if (redirect_in && busy_out) begin
               active     = 1;
               exp_pc     = int'(redirect_pc_in);
               stall_hold = 0;
            end else if (start_in && !busy_out) begin
               active     = 1;
               exp_pc     = 0;
               stall_hold = 0;
            end
         end
      end
   end

   initial begin
      int n;
      int n_issue;
      int max_addr;
      logic [31:0] r;

      for (int i = 0; i < IC; i++) begin
         r = $urandom();
         mem[i] = {r[22:0], 9'(i)};
      end

      #12;
      check_all_zero("reset");
      @(negedge clk_in);
      rst_n_in = 1'b1;
      tick();

      // Back-to-back stream with ready held high
      instr_ready_in = 1'b1;
      start_in = 1'b1;
      tick();
      start_in = 1'b0;
      check("t1_issue_en", bram_en_out, 1);
      check("t1_issue_addr", bram_addr_out, 0);
      check("t1_busy", busy_out, 1);
      wait_valid(n, 20);
      check("t1_latency", n, 3);
      for (int i = 0; i < 8; i++) begin
         check("t1_no_gap", instr_valid_out, 1);
         tick();
      end

      // Stall: credit stops issue at DEPTH outstanding words, head stays PC 0
      halt_in = 1'b1;
      tick();
      halt_in = 1'b0;
      instr_ready_in = 1'b0;
      start_in = 1'b1;
      tick();
      start_in = 1'b0;
      n_issue = 0;
      for (int i = 0; i < 13; i++) begin
         if (bram_en_out) n_issue++;
         if (instr_valid_out) check("t2_head_pc", instr_pc_out, 0);
         tick();
      end
      check("t2_issued", n_issue, DEPTH);
      check("t2_en_low", bram_en_out, 0);
      check("t2_head_valid", instr_valid_out, 1);
      instr_ready_in = 1'b1;
      for (int i = 0; i < 10; i++) tick();
      check("t2_flowing", instr_valid_out, 1);

      // Redirect with 3,4 buffered and 5,6 in flight
      halt_in = 1'b1;
      tick();
      halt_in = 1'b0;
      start_in = 1'b1;
      tick();
      start_in = 1'b0;
      n = 0;
      while (!(instr_valid_out && instr_pc_out == 3) && n < 20) begin
         tick();
         n++;
      end
      check("t3_reach_pc3", instr_pc_out, 3);
      instr_ready_in = 1'b0;
      tick();
      check("t3_credit_full", bram_en_out, 0);
      check("t3_head", instr_pc_out, 3);
      redirect_in = 1'b1;
      redirect_pc_in = 9'd100;
      tick();
      redirect_in = 1'b0;
      instr_ready_in = 1'b1;
      check("t3_flushed", instr_valid_out, 0);
      check("t3_issue_en", bram_en_out, 1);
      check("t3_issue_addr", bram_addr_out, 100);
      wait_valid(n, 10);
      check("t3_latency", n, 3);
      check("t3_target", instr_pc_out, 100);
      tick();
      check("t3_next", instr_pc_out, 101);

      // Halt beats a simultaneous redirect
      halt_in = 1'b1;
      redirect_in = 1'b1;
      redirect_pc_in = 9'd7;
      tick();
      halt_in = 1'b0;
      redirect_in = 1'b0;
      check("t4_busy", busy_out, 0);
      check("t4_valid", instr_valid_out, 0);
      check("t4_en", bram_en_out, 0);
      for (int i = 0; i < 4; i++) begin
         tick();
         check("t4_no_issue", bram_en_out, 0);
      end

      // Run off the end of the program, then redirect back to 0
      start_in = 1'b1;
      tick();
      start_in = 1'b0;
      redirect_in = 1'b1;
      redirect_pc_in = 9'd505;
      tick();
      redirect_in = 1'b0;
      max_addr = 0;
      for (int i = 0; i < 30; i++) begin
         if (bram_en_out && int'(bram_addr_out) > max_addr) max_addr = int'(bram_addr_out);
         tick();
      end
      check("t5_max_addr", max_addr, IC - 1);
      check("t5_last_accepted", last_acc, IC - 1);
      check("t5_drained", instr_valid_out, 0);
      check("t5_no_issue", bram_en_out, 0);
      check("t5_busy", busy_out, 1);
      redirect_in = 1'b1;
      redirect_pc_in = 9'd0;
      tick();
      redirect_in = 1'b0;
      check("t5_resume_en", bram_en_out, 1);
      check("t5_resume_addr", bram_addr_out, 0);
      wait_valid(n, 10);
      check("t5_resume_pc", instr_pc_out, 0);

      // Asynchronous reset between edges, then restart
      for (int i = 0; i < 5; i++) tick();
      @(posedge clk_in);
      #3;
      rst_n_in = 1'b0;
      #1;
      check_all_zero("t6_async");
      tick();
      tick();
      @(posedge clk_in);
      #3;
      rst_n_in = 1'b1;
      tick();
      check_all_zero("t6_released");
      start_in = 1'b1;
      tick();
      start_in = 1'b0;
      wait_valid(n, 20);
      check("t6_latency", n, 3);
      check("t6_first_pc", instr_pc_out, 0);

      // Random ready, redirects, halts and starts
      for (int c = 0; c < 800; c++) begin
         n = int'($urandom_range(0, 99));
         instr_ready_in = ($urandom_range(0, 3) != 0);
         redirect_in    = (n < 3);
         halt_in        = (n == 3);
         start_in       = (n >= 4 && n < 8);
         redirect_pc_in = PW'($urandom_range(0, IC - 1));
         tick();
      end
      redirect_in = 1'b0;
      start_in = 1'b0;
      halt_in = 1'b1;
      tick();
      halt_in = 1'b0;
      check("end_busy", busy_out, 0);
      tick();
      tick();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
